// File: rtl/vx_interp_pkg.sv
// Shared types and CSR map for the plane-equation interpolator.
// Struct widths follow the package defaults, which the top-level parameters also default to.
package vx_interp_pkg;

    localparam int unsigned IP_DATA_W    = 32;
    localparam int unsigned IP_NUM_LANES = 4;
    localparam int unsigned IP_UUID_W    = 44;
    localparam int unsigned IP_NW_BITS   = 2;
    localparam int unsigned IP_NR_BITS   = 5;

    localparam logic [11:0] CSR_INTER_BASE = 12'h7C0;
    localparam logic [1:0]  OFF_A          = 2'd0;
    localparam logic [1:0]  OFF_B          = 2'd1;
    localparam logic [1:0]  OFF_C          = 2'd2;
    localparam logic [1:0]  OFF_CTRL       = 2'd3;
    localparam int unsigned CTRL_SAT_EN    = 0;

    typedef struct packed {
        logic signed [IP_DATA_W-1:0] a;
        logic signed [IP_DATA_W-1:0] b;
        logic signed [IP_DATA_W-1:0] c;
    } coeff_t;

    typedef struct packed {
        logic [IP_UUID_W-1:0]    uuid;
        logic [IP_NW_BITS-1:0]   wid;
        logic [IP_NUM_LANES-1:0] tmask;
        logic [31:0]             PC;
        logic [IP_NR_BITS-1:0]   rd;
        logic                    wb;
    } interp_tag_t;

endpackage

// File: rtl/vx_interp_lane.sv
// One lane of the interpolator: multiply, sum with shifted c, then round and saturate/wrap.
// All three registers advance together under en; inactive lanes see zeroed operands.
module vx_interp_lane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     active,
    input  logic                     sat_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    output logic        [DATA_W-1:0] result
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = 2 * DATA_W + 2;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC_W - 1);

    logic signed [DATA_W-1:0] a_g, b_g, c_g, x_g, y_g;
    logic signed [PW-1:0]     prod_a_d, prod_b_d;
    logic signed [PW-1:0]     prod_a_q, prod_b_q;
    logic signed [DATA_W-1:0] c_q;
    logic                     sat0_q, sat1_q;
    logic signed [SW-1:0]     sum_d, sum_q, rnd, shifted;
    logic                     ovf;
    logic        [DATA_W-1:0] res_d, res_q;

    always_comb begin
        a_g = active ? a : '0;
        b_g = active ? b : '0;
        c_g = active ? c : '0;
        x_g = active ? x : '0;
        y_g = active ? y : '0;
        prod_a_d = PW'(a_g) * PW'(x_g);
        prod_b_d = PW'(b_g) * PW'(y_g);
    end

    always_comb begin
        sum_d = SW'(prod_a_q) + SW'(prod_b_q) + (SW'(c_q) <<< FRAC_W);
    end

    // Overflow when the bits above the result's sign bit are not a pure sign extension.
    always_comb begin
        rnd     = sum_q + HALF;
        shifted = rnd >>> FRAC_W;
        ovf     = (shifted[SW-1:DATA_W-1] != '0) && (shifted[SW-1:DATA_W-1] != '1);
        if (sat1_q && ovf) begin
            res_d = shifted[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            res_d = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_a_q <= '0;
            prod_b_q <= '0;
            c_q      <= '0;
            sat0_q   <= 1'b0;
            sum_q    <= '0;
            sat1_q   <= 1'b0;
            res_q    <= '0;
        end else if (en) begin
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
            c_q      <= c_g;
            sat0_q   <= sat_en;
            sum_q    <= sum_d;
            sat1_q   <= sat0_q;
            res_q    <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/vx_interp_pipe.sv
// Pipelined plane-equation interpolator: per lane a*x + b*y + c, with a CSR-programmed
// coefficient file, tag pass-through and a global stall driven by the output register.
module vx_interp_pipe
    import vx_interp_pkg::*;
#(
    parameter int unsigned NUM_LANES = IP_NUM_LANES,
    parameter int unsigned NUM_ATTRS = 4,
    parameter int unsigned DATA_W    = IP_DATA_W,
    parameter int unsigned FRAC_W    = 16,
    parameter int unsigned UUID_W    = IP_UUID_W,
    parameter int unsigned NW_BITS   = IP_NW_BITS,
    parameter int unsigned NR_BITS   = IP_NR_BITS,
    parameter int unsigned ATTR_W    = (NUM_ATTRS > 1) ? $clog2(NUM_ATTRS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        csr_we,
    input  logic [11:0]                 csr_addr,
    input  logic [31:0]                 csr_wdata,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ATTR_W-1:0]           req_attr_id,
    input  logic [NUM_LANES*DATA_W-1:0] req_x,
    input  logic [NUM_LANES*DATA_W-1:0] req_y,
    input  logic [UUID_W-1:0]           req_uuid,
    input  logic [NW_BITS-1:0]          req_wid,
    input  logic [NUM_LANES-1:0]        req_tmask,
    input  logic [31:0]                 req_PC,
    input  logic [NR_BITS-1:0]          req_rd,
    input  logic                        req_wb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NUM_LANES*DATA_W-1:0] rsp_data,
    output logic [UUID_W-1:0]           rsp_uuid,
    output logic [NW_BITS-1:0]          rsp_wid,
    output logic [NUM_LANES-1:0]        rsp_tmask,
    output logic [31:0]                 rsp_PC,
    output logic [NR_BITS-1:0]          rsp_rd,
    output logic                        rsp_wb
);

    coeff_t                 coeff_q [NUM_ATTRS];
    logic [NUM_ATTRS-1:0]   sat_q;
    logic [11:0]            csr_off;
    logic                   csr_hit;
    logic [ATTR_W-1:0]      csr_attr;
    logic [1:0]             csr_field;

    logic                   stall, en, fire, sel_sat;
    coeff_t                 sel_coeff;
    interp_tag_t            req_tag, t0_q, t1_q, t2_q;
    logic                   v0_q, v1_q, v2_q;

    always_comb begin
        csr_off   = csr_addr - CSR_INTER_BASE;
        csr_hit   = csr_we && (csr_addr >= CSR_INTER_BASE) && (csr_off < 12'(4 * NUM_ATTRS));
        csr_attr  = csr_off[ATTR_W+1:2];
        csr_field = csr_off[1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_ATTRS; i++) begin
                coeff_q[i] <= '0;
            end
            sat_q <= '0;
        end else if (csr_hit) begin
            case (csr_field)
                OFF_A:   coeff_q[csr_attr].a <= csr_wdata[DATA_W-1:0];
                OFF_B:   coeff_q[csr_attr].b <= csr_wdata[DATA_W-1:0];
                OFF_C:   coeff_q[csr_attr].c <= csr_wdata[DATA_W-1:0];
                default: sat_q[csr_attr]     <= csr_wdata[CTRL_SAT_EN];
            endcase
        end
    end

    // Coefficient reads see the pre-write value; lanes register them at acceptance.
    always_comb begin
        stall     = v2_q && !rsp_ready;
        en        = !stall;
        req_ready = reset && en;
        fire      = req_valid && req_ready;
        sel_coeff = coeff_q[req_attr_id];
        sel_sat   = sat_q[req_attr_id];
        req_tag   = '{uuid: req_uuid, wid: req_wid, tmask: req_tmask,
                      PC: req_PC, rd: req_rd, wb: req_wb};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            t0_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
        end else if (en) begin
            v0_q <= fire;
            v1_q <= v0_q;
            v2_q <= v1_q;
            t0_q <= fire ? req_tag : '0;
            t1_q <= t0_q;
            t2_q <= t1_q;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vx_interp_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .active (fire && req_tmask[g]),
            .sat_en (sel_sat),
            .a      (sel_coeff.a),
            .b      (sel_coeff.b),
            .c      (sel_coeff.c),
            .x      (req_x[g*DATA_W +: DATA_W]),
            .y      (req_y[g*DATA_W +: DATA_W]),
            .result (rsp_data[g*DATA_W +: DATA_W])
        );
    end

    assign rsp_valid = v2_q;
    assign rsp_uuid  = t2_q.uuid;
    assign rsp_wid   = t2_q.wid;
    assign rsp_tmask = t2_q.tmask;
    assign rsp_PC    = t2_q.PC;
    assign rsp_rd    = t2_q.rd;
    assign rsp_wb    = t2_q.wb;

endmodule

// File: tb/tb_vx_interp_pipe.sv
// Self-checking bench for vx_interp_pipe: directed scenarios plus a randomized run
// against a wide-integer arithmetic model of the interpolation and the CSR file.
module tb_vx_interp_pipe;
    import vx_interp_pkg::*;

    localparam int NL = 4;
    localparam int NA = 4;
    localparam int DW = 32;

    logic            clk, reset, csr_we, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata, req_PC, rsp_PC;
    logic [1:0]      req_attr_id, req_wid, rsp_wid;
    logic [NL*DW-1:0] req_x, req_y, rsp_data;
    logic [43:0]     req_uuid, rsp_uuid;
    logic [NL-1:0]   req_tmask, rsp_tmask;
    logic [4:0]      req_rd, rsp_rd;
    logic            req_wb, rsp_wb;

    typedef struct packed {
        logic [NL*DW-1:0] data;
        logic [43:0]      uuid;
        logic [1:0]       wid;
        logic [NL-1:0]    tmask;
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic             wb;
    } rsp_t;

    rsp_t        exp_q[$], got_q[$];
    logic [31:0] m_a[NA], m_b[NA], m_c[NA];
    bit          m_sat[NA];
    int          n_checks = 0, n_pass = 0;

    vx_interp_pipe #(
        .NUM_LANES (NL), .NUM_ATTRS (NA), .DATA_W (DW), .FRAC_W (16),
        .UUID_W (44), .NW_BITS (2), .NR_BITS (5)
    ) dut (
        .clk (clk), .reset (reset), .csr_we (csr_we), .csr_addr (csr_addr), .csr_wdata (csr_wdata),
        .req_valid (req_valid), .req_ready (req_ready), .req_attr_id (req_attr_id),
        .req_x (req_x), .req_y (req_y), .req_uuid (req_uuid), .req_wid (req_wid),
        .req_tmask (req_tmask), .req_PC (req_PC), .req_rd (req_rd), .req_wb (req_wb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
        .rsp_uuid (rsp_uuid), .rsp_wid (rsp_wid), .rsp_tmask (rsp_tmask),
        .rsp_PC (rsp_PC), .rsp_rd (rsp_rd), .rsp_wb (rsp_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // value = (a*x + b*y + c*2^16 + 2^15) / 2^16 rounded toward -inf, then clamp or wrap
    function automatic logic [31:0] ref_lane(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                             logic [31:0] x, logic [31:0] y, bit sat, bit act);
        logic signed [127:0] sa, sb, sc, sx, sy, s;
        if (!act) return 32'h0;
        sa = $signed(a); sb = $signed(b); sc = $signed(c); sx = $signed(x); sy = $signed(y);
        s = sa * sx + sb * sy + sc * 128'sd65536 + 128'sd32768;
        s = s >>> 16;
        if (sat && s > 128'sd2147483647)  return 32'h7FFF_FFFF;
        if (sat && s < -128'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic tick();
        rsp_t e, g;
        int   off;
        if (reset && req_valid && req_ready) begin
            for (int l = 0; l < NL; l++)
                e.data[l*DW +: DW] = ref_lane(m_a[req_attr_id], m_b[req_attr_id], m_c[req_attr_id],
                                              req_x[l*DW +: DW], req_y[l*DW +: DW],
                                              m_sat[req_attr_id], req_tmask[l]);
            e.uuid = req_uuid; e.wid = req_wid; e.tmask = req_tmask;
            e.pc = req_PC; e.rd = req_rd; e.wb = req_wb;
            exp_q.push_back(e);
        end
        if (reset && rsp_valid && rsp_ready) begin
            g.data = rsp_data; g.uuid = rsp_uuid; g.wid = rsp_wid; g.tmask = rsp_tmask;
            g.pc = rsp_PC; g.rd = rsp_rd; g.wb = rsp_wb;
            got_q.push_back(g);
        end
        if (!reset) begin
            for (int i = 0; i < NA; i++) begin
                m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; m_sat[i] = 0;
            end
            exp_q.delete();
        end else if (csr_we) begin
            off = int'(csr_addr) - int'(CSR_INTER_BASE);
            if (off >= 0 && off < 4 * NA) begin
                case (off % 4)
                    0: m_a[off / 4] = csr_wdata;
                    1: m_b[off / 4] = csr_wdata;
                    2: m_c[off / 4] = csr_wdata;
                    default: m_sat[off / 4] = csr_wdata[0];
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(int attr, logic [1:0] field, logic [31:0] d);
        csr_we = 1'b1;
        csr_addr = CSR_INTER_BASE + 12'(attr * 4) + 12'(field);
        csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic set_req(int attr, logic [NL-1:0] tm, logic [31:0] x, logic [31:0] y);
        req_valid = 1'b1;
        req_attr_id = 2'(attr);
        req_tmask = tm;
        req_x = {NL{x}};
        req_y = {NL{y}};
        req_uuid = {12'($urandom), 32'($urandom)};
        req_wid = 2'($urandom);
        req_PC = $urandom;
        req_rd = 5'($urandom);
        req_wb = 1'($urandom);
    endtask

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_checks++;
        if ({rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb} !== '0)
            $display("FAIL reset_tags: got %h want 0", {rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb});
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        csr_wr(0, OFF_A, 32'h0001_0000);
        csr_wr(0, OFF_B, 32'h0002_0000);
        csr_wr(0, OFF_C, 32'h0000_8000);
        csr_wr(0, OFF_CTRL, 32'h1);
        set_req(0, 4'hF, 32'h0003_0000, 32'h0001_0000);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_checks++; if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat); else n_pass++;
        n_checks++;
        if (rsp_data !== {NL{32'h0005_8000}}) $display("FAIL basic_data: got %h want %h", rsp_data, {NL{32'h0005_8000}});
        else n_pass++;
        tick();
    endtask

    task automatic test_saturate();
        logic [31:0] xs[3] = '{32'h7FFF_0000, 32'h8001_0000, 32'h7FFF_0000};
        logic [31:0] ws[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000};
        int lat;
        csr_wr(2, OFF_A, 32'h7FFF_0000);
        csr_wr(2, OFF_B, 32'h0);
        csr_wr(2, OFF_C, 32'h0);
        csr_wr(2, OFF_CTRL, 32'h1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) csr_wr(2, OFF_CTRL, 32'h0);
            set_req(2, 4'hF, xs[k], $urandom);
            tick();
            req_valid = 1'b0;
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
            n_checks++;
            if (rsp_data !== {NL{ws[k]}}) $display("FAIL saturate_case%0d: got %h want %h", k, rsp_data, {NL{ws[k]}});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_csr_race();
        int lat;
        csr_wr(1, OFF_A, 32'h0001_0000);
        csr_wr(1, OFF_B, 32'h0);
        csr_wr(1, OFF_C, 32'h0);
        csr_wr(1, OFF_CTRL, 32'h1);
        set_req(1, 4'hF, 32'h0001_0000, $urandom);
        csr_we = 1'b1;
        csr_addr = CSR_INTER_BASE + 12'd4 + 12'(OFF_A);
        csr_wdata = 32'h0002_0000;
        tick();
        csr_we = 1'b0;
        set_req(1, 4'hF, 32'h0001_0000, $urandom);
        tick();
        req_valid = 1'b0;
        lat = 2;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_checks++;
        if (rsp_data !== {NL{32'h0001_0000}}) $display("FAIL race_old_value: got %h want %h", rsp_data, {NL{32'h0001_0000}});
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== {NL{32'h0002_0000}})
            $display("FAIL race_new_value: got v=%b %h want v=1 %h", rsp_valid, rsp_data, {NL{32'h0002_0000}});
        else n_pass++;
        tick();
    endtask

    task automatic test_tmask();
        int lat;
        csr_wr(3, OFF_A, 32'h0001_0000);
        csr_wr(3, OFF_B, 32'h0001_0000);
        csr_wr(3, OFF_C, 32'h0);
        csr_wr(3, OFF_CTRL, 32'h1);
        set_req(3, 4'b0101, 32'h0001_0000, 32'h0001_0000);
        req_uuid = 44'h123_4567_89AB; req_wid = 2'd2; req_PC = 32'h8000_1234; req_rd = 5'd17; req_wb = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_checks++;
        if (rsp_data !== {32'h0, 32'h0002_0000, 32'h0, 32'h0002_0000})
            $display("FAIL tmask_data: got %h want %h", rsp_data, {32'h0, 32'h0002_0000, 32'h0, 32'h0002_0000});
        else n_pass++;
        n_checks++; if (rsp_tmask !== 4'b0101) $display("FAIL tmask_echo: got %b want 0101", rsp_tmask); else n_pass++;
        n_checks++; if (rsp_uuid !== 44'h123_4567_89AB) $display("FAIL tmask_uuid: got %h want 123456789ab", rsp_uuid); else n_pass++;
        n_checks++; if (rsp_PC !== 32'h8000_1234) $display("FAIL tmask_pc: got %h want 80001234", rsp_PC); else n_pass++;
        n_checks++;
        if (rsp_rd !== 5'd17 || rsp_wb !== 1'b1 || rsp_wid !== 2'd2)
            $display("FAIL tmask_rd_wb_wid: got %0d %b %0d want 17 1 2", rsp_rd, rsp_wb, rsp_wid);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int  sent = 0, cyc = 0, first_stall = -1;
        bit  acc, need_new = 1;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0;
        while (sent < 4 && cyc < 40) begin
            if (need_new) begin
                set_req(int'($urandom_range(0, NA - 1)), 4'($urandom), rnd_val(), rnd_val());
                need_new = 0;
            end
            rsp_ready = (cyc >= 5);
            #1;
            if (req_ready === 1'b0 && first_stall < 0) first_stall = cyc;
            acc = (req_ready === 1'b1);
            tick();
            if (acc) begin sent++; need_new = 1; end
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (got_q.size() < 4 && cyc < 80) begin tick(); cyc++; end
        n_checks++; if (first_stall !== 3) $display("FAIL b2b_stall_cycle: got %0d want 3", first_stall); else n_pass++;
        n_checks++; if (sent !== 4) $display("FAIL b2b_sent: got %0d want 4", sent); else n_pass++;
        n_checks++;
        if (got_q.size() !== 4 || exp_q.size() !== 4)
            $display("FAIL b2b_count: got %0d rsp / %0d exp want 4", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 400; i++) begin
            csr_we = ($urandom_range(0, 3) == 0);
            csr_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : CSR_INTER_BASE + 12'($urandom_range(0, 15));
            csr_wdata = rnd_val();
            if (!req_valid || req_ready) begin
                if ($urandom_range(0, 3) != 0) set_req(int'($urandom_range(0, NA - 1)), 4'($urandom), rnd_val(), rnd_val());
                else req_valid = 1'b0;
                req_x = {rnd_val(), rnd_val(), rnd_val(), rnd_val()};
                req_y = {rnd_val(), rnd_val(), rnd_val(), rnd_val()};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            tick();
        end
        csr_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && cyc < 50) begin tick(); cyc++; end
        tick(); tick(); tick();
        n_checks++;
        if (got_q.size() !== exp_q.size() || exp_q.size() < 100)
            $display("FAIL random_count: got %0d rsp want %0d (>=100)", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL random_rsp%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        exp_q.delete(); got_q.delete();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 4'hF, rnd_val(), rnd_val());
            tick();
        end
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL midflight_full: got %b want 1", rsp_valid); else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL midflight_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (got_q.size() !== 0) $display("FAIL midflight_stale: got %0d rsp want 0", got_q.size()); else n_pass++;
        set_req(0, 4'hF, 32'h0003_0000, 32'h0001_0000);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== '0) $display("FAIL midflight_coeff_zero: got v=%b %h want v=1 0", rsp_valid, rsp_data);
        else n_pass++;
        tick();
    endtask

    initial begin
        reset = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        req_valid = 1'b0; req_attr_id = '0; req_x = '0; req_y = '0;
        req_uuid = '0; req_wid = '0; req_tmask = '0; req_PC = '0; req_rd = '0; req_wb = 1'b0;
        rsp_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturate();
        test_csr_race();
        test_tmask();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
